// File: rtl/audio_pkg.sv
// Shared widths, limits and FSM state encoding for the audio playback controller.
// Optional looping playback is enabled with the AUDIO_LOOP_EN macro (see audio_playback_controller).
package audio_pkg;

   localparam int WORD_W          = 16;
   localparam int BITS_PER_WORD   = 16;
   localparam int MIN_MEM_LATENCY = 1;
   localparam int MAX_MEM_LATENCY = 12;

   typedef enum logic [1:0] {
      PB_IDLE   = 2'd0,
      PB_FETCH0 = 2'd1,
      PB_RUN    = 2'd2,
      PB_DRAIN  = 2'd3
   } pb_state_t;

   function automatic bit latency_ok(input int lat);
      return (lat >= MIN_MEM_LATENCY) && (lat <= MAX_MEM_LATENCY);
   endfunction

endpackage

// File: rtl/word_fetcher.sv
// Issues one sample-memory read per request and flags the cycle its data is valid.
// Used for both the first word of a range and every prefetch behind it.
module word_fetcher
   import audio_pkg::*;
#(
   parameter int ADDR_W      = 16,
   parameter int MEM_LATENCY = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              flush_i,
   input  logic              req_i,
   input  logic [ADDR_W-1:0] addr_i,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic              mem_rd_o,
   input  logic [WORD_W-1:0] mem_data_i,
   output logic [WORD_W-1:0] data_o,
   output logic              valid_o
);

   logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
   logic                   mem_rd_q, mem_rd_d;
   logic [MEM_LATENCY-1:0] pipe_q, pipe_d;

   // req_i is a one-cycle strobe with no back-pressure: the read goes out the next
   // cycle and valid_o is high for exactly the one cycle mem_data_i carries the word.
   // flush_i drops any read still in flight so its data is never reported.
   always_comb begin
      mem_rd_d   = req_i & ~flush_i;
      mem_addr_d = req_i ? addr_i : mem_addr_q;
      pipe_d     = '0;
      pipe_d[0]  = mem_rd_q & ~flush_i;
      for (int i = 1; i < MEM_LATENCY; i++) begin
         pipe_d[i] = pipe_q[i-1] & ~flush_i;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mem_addr_q <= '0;
         mem_rd_q   <= 1'b0;
         pipe_q     <= '0;
      end else begin
         mem_addr_q <= mem_addr_d;
         mem_rd_q   <= mem_rd_d;
         pipe_q     <= pipe_d;
      end
   end

   assign mem_addr_o = mem_addr_q;
   assign mem_rd_o   = mem_rd_q;
   assign data_o     = mem_data_i;
   assign valid_o    = pipe_q[MEM_LATENCY-1];

endmodule

// File: rtl/audio_playback_controller.sv
// Walks a word range in sample memory and feeds the 16-bit serializer gaplessly via a shadow prefetch.
// Define AUDIO_LOOP_EN to add the `loop` input that restarts the range instead of draining.
module audio_playback_controller
   import audio_pkg::*;
#(
   parameter int ADDR_W      = 16,
   parameter int MEM_LATENCY = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              play,
   input  logic              stop,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [ADDR_W-1:0] end_addr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [WORD_W-1:0] mem_data,
   output logic [WORD_W-1:0] ser_data,
   output logic              ser_enable,
   input  logic              ser_done,
   output logic              busy,
   output logic              finished,
   output logic [1:0]        dbg_state
`ifdef AUDIO_LOOP_EN
   ,
   input  logic              loop
`endif
);

   if (!latency_ok(MEM_LATENCY)) begin : g_bad_latency
      $error("audio_playback_controller: MEM_LATENCY must be within 1..12");
   end

   pb_state_t         state_q, state_d;
   logic [ADDR_W-1:0] start_q, start_d;
   logic [ADDR_W-1:0] end_q, end_d;
   logic [ADDR_W-1:0] cur_q, cur_d;
   logic [WORD_W-1:0] shadow_q, shadow_d;
   logic              shadow_vld_q, shadow_vld_d;
   logic [WORD_W-1:0] ser_data_q, ser_data_d;
   logic              ser_en_q, ser_en_d;
   logic              fin_q, fin_d;

   logic              fetch_req;
   logic [ADDR_W-1:0] fetch_addr;
   logic              fetch_flush;
   logic [WORD_W-1:0] fetch_data;
   logic              fetch_valid;
   logic              loop_en;
   logic [ADDR_W-1:0] cur_inc, cur_inc2, start_inc;

`ifdef AUDIO_LOOP_EN
   assign loop_en = loop;
`else
   assign loop_en = 1'b0;
`endif

   assign cur_inc   = cur_q + ADDR_W'(1);
   assign cur_inc2  = cur_q + ADDR_W'(2);
   assign start_inc = start_q + ADDR_W'(1);

   word_fetcher #(
      .ADDR_W      (ADDR_W),
      .MEM_LATENCY (MEM_LATENCY)
   ) u_fetch (
      .clock      (clock),
      .reset      (reset),
      .flush_i    (fetch_flush),
      .req_i      (fetch_req),
      .addr_i     (fetch_addr),
      .mem_addr_o (mem_addr),
      .mem_rd_o   (mem_rd),
      .mem_data_i (mem_data),
      .data_o     (fetch_data),
      .valid_o    (fetch_valid)
   );

   always_comb begin
      state_d      = state_q;
      start_d      = start_q;
      end_d        = end_q;
      cur_d        = cur_q;
      shadow_d     = shadow_q;
      shadow_vld_d = shadow_vld_q;
      ser_data_d   = ser_data_q;
      ser_en_d     = ser_en_q;
      fin_d        = 1'b0;
      fetch_req    = 1'b0;
      fetch_addr   = cur_q;
      fetch_flush  = 1'b0;

      unique case (state_q)
         PB_IDLE: begin
            if (play && !stop) begin
               if (start_addr <= end_addr) begin
                  start_d      = start_addr;
                  end_d        = end_addr;
                  cur_d        = start_addr;
                  shadow_vld_d = 1'b0;
                  fetch_req    = 1'b1;
                  fetch_addr   = start_addr;
                  state_d      = PB_FETCH0;
               end else begin
                  fin_d = 1'b1;
               end
            end
         end

         PB_FETCH0: begin
            if (stop) begin
               fetch_flush  = 1'b1;
               ser_en_d     = 1'b0;
               shadow_vld_d = 1'b0;
               state_d      = PB_IDLE;
            end else if (fetch_valid) begin
               ser_data_d = fetch_data;
               ser_en_d   = 1'b1;
               state_d    = PB_RUN;
               if (cur_q != end_q) begin
                  fetch_req  = 1'b1;
                  fetch_addr = cur_inc;
               end else if (loop_en) begin
                  fetch_req  = 1'b1;
                  fetch_addr = start_q;
               end
            end
         end

         PB_RUN: begin
            if (stop) begin
               fetch_flush  = 1'b1;
               ser_en_d     = 1'b0;
               shadow_vld_d = 1'b0;
               state_d      = PB_IDLE;
            end else begin
               if (fetch_valid) begin
                  shadow_d     = fetch_data;
                  shadow_vld_d = 1'b1;
               end
               if (ser_done) begin
                  if (cur_q != end_q) begin
                     ser_data_d   = shadow_q;
                     shadow_vld_d = 1'b0;
                     cur_d        = cur_inc;
                     // Never read past end_addr; this also keeps an all-ones end from wrapping.
                     if (cur_inc != end_q) begin
                        fetch_req  = 1'b1;
                        fetch_addr = cur_inc2;
                     end else if (loop_en) begin
                        fetch_req  = 1'b1;
                        fetch_addr = start_q;
                     end
                  end else if (loop_en && shadow_vld_q) begin
                     ser_data_d   = shadow_q;
                     shadow_vld_d = 1'b0;
                     cur_d        = start_q;
                     fetch_req    = 1'b1;
                     fetch_addr   = (start_q != end_q) ? start_inc : start_q;
                  end else begin
                     ser_en_d = 1'b0;
                     fin_d    = 1'b1;
                     state_d  = PB_DRAIN;
                  end
               end
            end
         end

         PB_DRAIN: begin
            fetch_flush  = stop;
            shadow_vld_d = 1'b0;
            state_d      = PB_IDLE;
         end

         default: begin
            state_d = PB_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= PB_IDLE;
         start_q      <= '0;
         end_q        <= '0;
         cur_q        <= '0;
         shadow_q     <= '0;
         shadow_vld_q <= 1'b0;
         ser_data_q   <= '0;
         ser_en_q     <= 1'b0;
         fin_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         start_q      <= start_d;
         end_q        <= end_d;
         cur_q        <= cur_d;
         shadow_q     <= shadow_d;
         shadow_vld_q <= shadow_vld_d;
         ser_data_q   <= ser_data_d;
         ser_en_q     <= ser_en_d;
         fin_q        <= fin_d;
      end
   end

   assign ser_data   = ser_data_q;
   assign ser_enable = ser_en_q;
   assign busy       = (state_q != PB_IDLE);
   assign finished   = fin_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_audio_playback_controller.sv
// Directed bench for audio_playback_controller: two instances (memory latency 1 and 12)
// share the control inputs; each has its own memory model, serializer model and recorder.
`timescale 1ns/1ps
module tb_audio_playback_controller;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        play  = 1'b0;
   logic        stop  = 1'b0;
   logic [15:0] start_addr = '0;
   logic [15:0] end_addr   = '0;
`ifdef AUDIO_LOOP_EN
   logic        loop = 1'b0;
`endif
   logic        clr  = 1'b0;

   logic [15:0] mem_addr_a, mem_data_a, ser_data_a;
   logic        mem_rd_a, ser_enable_a, ser_done_a, busy_a, finished_a;
   logic [1:0]  dbg_state_a;
   logic [15:0] mem_addr_b, mem_data_b, ser_data_b;
   logic        mem_rd_b, ser_enable_b, ser_done_b, busy_b, finished_b;
   logic [1:0]  dbg_state_b;

   logic [15:0] mem [0:255];
   logic [15:0] mdat_a;
   logic [15:0] pipe_b [0:11];

   int n_checks = 0;
   int n_bad    = 0;

   logic [15:0] exp_q[$];
   logic [15:0] exp_rd_q[$];

   // clock / reset block
   always #5 clock = ~clock;

   audio_playback_controller #(.ADDR_W(16), .MEM_LATENCY(1)) u_dut_a (
      .clock(clock), .reset(reset), .play(play), .stop(stop),
      .start_addr(start_addr), .end_addr(end_addr),
      .mem_addr(mem_addr_a), .mem_rd(mem_rd_a), .mem_data(mem_data_a),
      .ser_data(ser_data_a), .ser_enable(ser_enable_a), .ser_done(ser_done_a),
      .busy(busy_a), .finished(finished_a), .dbg_state(dbg_state_a)
`ifdef AUDIO_LOOP_EN
      , .loop(loop)
`endif
   );

   audio_playback_controller #(.ADDR_W(16), .MEM_LATENCY(12)) u_dut_b (
      .clock(clock), .reset(reset), .play(play), .stop(stop),
      .start_addr(start_addr), .end_addr(end_addr),
      .mem_addr(mem_addr_b), .mem_rd(mem_rd_b), .mem_data(mem_data_b),
      .ser_data(ser_data_b), .ser_enable(ser_enable_b), .ser_done(ser_done_b),
      .busy(busy_b), .finished(finished_b), .dbg_state(dbg_state_b)
`ifdef AUDIO_LOOP_EN
      , .loop(loop)
`endif
   );

   // sync-read sample memories, latency 1 and 12
   always @(posedge clock) mdat_a <= mem[mem_addr_a[7:0]];
   assign mem_data_a = mdat_a;

   always @(posedge clock) begin
      pipe_b[0] <= mem[mem_addr_b[7:0]];
      for (int i = 1; i < 12; i++) pipe_b[i] <= pipe_b[i-1];
   end
   assign mem_data_b = pipe_b[11];

   // serializer models and recorders
   logic [3:0]  cnt_a = '0, cnt_b = '0;
   logic [15:0] sh_a = '0, sh_b = '0;
   logic        prev_en_a = 1'b0, prev_en_b = 1'b0;
   int          n_fin_a = 0, n_fin_b = 0, n_en_a = 0, n_en_b = 0, n_rise_a = 0, n_rise_b = 0;
   logic [15:0] rd_q_a[$], rd_q_b[$], word_q_a[$], word_q_b[$];

   assign ser_done_a = ser_enable_a && (cnt_a == 4'hF);
   assign ser_done_b = ser_enable_b && (cnt_b == 4'hF);

   always @(posedge clock) begin
      if (clr) begin
         cnt_a <= '0;
         n_fin_a = 0; n_en_a = 0; n_rise_a = 0; prev_en_a = 1'b0;
         rd_q_a.delete(); word_q_a.delete();
      end else begin
         if (mem_rd_a) rd_q_a.push_back(mem_addr_a);
         if (finished_a) n_fin_a++;
         if (ser_enable_a && !prev_en_a) n_rise_a++;
         prev_en_a = ser_enable_a;
         if (ser_enable_a) begin
            n_en_a++;
            sh_a = {sh_a[14:0], ser_data_a[4'd15 - cnt_a]};
            if (cnt_a == 4'hF) word_q_a.push_back(sh_a);
            cnt_a <= cnt_a + 4'd1;
         end else begin
            cnt_a <= '0;
         end
      end
   end

   always @(posedge clock) begin
      if (clr) begin
         cnt_b <= '0;
         n_fin_b = 0; n_en_b = 0; n_rise_b = 0; prev_en_b = 1'b0;
         rd_q_b.delete(); word_q_b.delete();
      end else begin
         if (mem_rd_b) rd_q_b.push_back(mem_addr_b);
         if (finished_b) n_fin_b++;
         if (ser_enable_b && !prev_en_b) n_rise_b++;
         prev_en_b = ser_enable_b;
         if (ser_enable_b) begin
            n_en_b++;
            sh_b = {sh_b[14:0], ser_data_b[4'd15 - cnt_b]};
            if (cnt_b == 4'hF) word_q_b.push_back(sh_b);
            cnt_b <= cnt_b + 4'd1;
         end else begin
            cnt_b <= '0;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_q(input string tag, input logic [15:0] got_q[$], input logic [15:0] want_q[$]);
      check({tag, "_len"}, 32'(got_q.size()), 32'(want_q.size()));
      for (int i = 0; i < want_q.size() && i < got_q.size(); i++)
         check($sformatf("%s[%0d]", tag, i), 32'(got_q[i]), 32'(want_q[i]));
   endtask

   // driver tasks
   task automatic clear_rec();
      @(negedge clock); clr = 1'b1;
      @(negedge clock); clr = 1'b0;
      exp_q.delete();
      exp_rd_q.delete();
   endtask

   task automatic build_range(input int s, input int e);
      for (int a = s; a <= e; a++) begin
         exp_rd_q.push_back(16'(a));
         exp_q.push_back(mem[a[7:0]]);
      end
   endtask

   task automatic do_play(input logic [15:0] s, input logic [15:0] e);
      @(negedge clock);
      start_addr = s; end_addr = e; play = 1'b1;
      @(negedge clock);
      play = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int k = 0;
      while ((busy_a || busy_b) && k < 800) begin
         @(negedge clock);
         k++;
      end
      check(tag, 32'(busy_a | busy_b), 32'd0);
   endtask

   task automatic wait_words_a(input string tag, input int n);
      int k = 0;
      while (word_q_a.size() < n && k < 800) begin
         @(negedge clock);
         k++;
      end
      check(tag, 32'(word_q_a.size() >= n), 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'(i * 37) ^ 16'h5A3C;
      mem[8'h10] = 16'hA5C3;

      // reset state
      repeat (3) @(negedge clock);
      check("rst_mem_rd",   32'(mem_rd_a),     32'd0);
      check("rst_mem_addr", 32'(mem_addr_a),   32'd0);
      check("rst_ser_en",   32'(ser_enable_a), 32'd0);
      check("rst_ser_data", 32'(ser_data_a),   32'd0);
      check("rst_busy",     32'(busy_a),       32'd0);
      check("rst_finished", 32'(finished_a),   32'd0);
      check("rst_state",    32'(dbg_state_a),  32'd0);
      check("rst_state_b",  32'(dbg_state_b),  32'd0);
      reset = 1'b0;

      // single word at 0x0010
      clear_rec();
      build_range(16'h10, 16'h10);
      do_play(16'h0010, 16'h0010);
      check("w1_mem_rd",   32'(mem_rd_a),    32'd1);
      check("w1_mem_addr", 32'(mem_addr_a),  32'h10);
      check("w1_state",    32'(dbg_state_a), 32'd1);
      check("w1_busy",     32'(busy_a),      32'd1);
      @(negedge clock);
      check("w1_en_early", 32'(ser_enable_a), 32'd0);
      @(negedge clock);
      check("w1_en_lat",   32'(ser_enable_a), 32'd1);
      check("w1_data",     32'(ser_data_a),   32'hA5C3);
      check("w1_no_pf",    32'(mem_rd_a),     32'd0);
      wait_idle("w1_idle");
      check_q("w1_rd_a", rd_q_a, exp_rd_q);
      check_q("w1_words_a", word_q_a, exp_q);
      check_q("w1_rd_b", rd_q_b, exp_rd_q);
      check_q("w1_words_b", word_q_b, exp_q);
      check("w1_fin_a", 32'(n_fin_a), 32'd1);
      check("w1_fin_b", 32'(n_fin_b), 32'd1);
      check("w1_en_a",  32'(n_en_a),  32'd16);

      // four words 0..3, gapless on both latencies
      clear_rec();
      build_range(0, 3);
      do_play(16'h0000, 16'h0003);
      check("w4_mem_rd",   32'(mem_rd_a),   32'd1);
      check("w4_mem_addr", 32'(mem_addr_a), 32'd0);
      repeat (2) @(negedge clock);
      check("w4_en_lat",   32'(ser_enable_a), 32'd1);
      check("w4_data0",    32'(ser_data_a),   32'(mem[0]));
      check("w4_pf_rd",    32'(mem_rd_a),     32'd1);
      check("w4_pf_addr",  32'(mem_addr_a),   32'd1);
      wait_idle("w4_idle");
      check_q("w4_rd_a", rd_q_a, exp_rd_q);
      check_q("w4_words_a", word_q_a, exp_q);
      check_q("w4_rd_b", rd_q_b, exp_rd_q);
      check_q("w4_words_b", word_q_b, exp_q);
      check("w4_en_a",   32'(n_en_a),   32'd64);
      check("w4_en_b",   32'(n_en_b),   32'd64);
      check("w4_rise_a", 32'(n_rise_a), 32'd1);
      check("w4_rise_b", 32'(n_rise_b), 32'd1);
      check("w4_fin_a",  32'(n_fin_a),  32'd1);
      check("w4_fin_b",  32'(n_fin_b),  32'd1);

      // empty range: start > end
      clear_rec();
      do_play(16'h0005, 16'h0004);
      check("emp_fin_a",  32'(finished_a), 32'd1);
      check("emp_fin_b",  32'(finished_b), 32'd1);
      check("emp_busy",   32'(busy_a),     32'd0);
      check("emp_mem_rd", 32'(mem_rd_a),   32'd0);
      @(negedge clock);
      check("emp_fin_off", 32'(finished_a), 32'd0);
      repeat (3) @(negedge clock);
      check("emp_rd_cnt", 32'(rd_q_a.size()), 32'd0);
      check("emp_en_cnt", 32'(n_en_a),        32'd0);
      check("emp_fin_cnt", 32'(n_fin_a),      32'd1);

      // stop mid word 2, then a fresh play restarts at start_addr
      clear_rec();
      do_play(16'h0000, 16'h0003);
      wait_words_a("stop_wait", 1);
      repeat (5) @(negedge clock);
      stop = 1'b1;
      @(negedge clock);
      stop = 1'b0;
      check("stop_en_a",  32'(ser_enable_a), 32'd0);
      check("stop_busy_a", 32'(busy_a),      32'd0);
      check("stop_rd_a",  32'(mem_rd_a),     32'd0);
      check("stop_busy_b", 32'(busy_b),      32'd0);
      repeat (20) @(negedge clock);
      check("stop_fin_a", 32'(n_fin_a), 32'd0);
      check("stop_fin_b", 32'(n_fin_b), 32'd0);
      clear_rec();
      build_range(0, 3);
      do_play(16'h0000, 16'h0003);
      wait_idle("rst_play_idle");
      check_q("replay_rd_a", rd_q_a, exp_rd_q);
      check_q("replay_words_a", word_q_a, exp_q);
      check("replay_fin_a", 32'(n_fin_a), 32'd1);

      // range ending at all-ones address: no wrap read
      clear_rec();
      build_range(16'hFFFE, 16'hFFFF);
      do_play(16'hFFFE, 16'hFFFF);
      wait_idle("top_idle");
      check_q("top_rd_a", rd_q_a, exp_rd_q);
      check_q("top_words_a", word_q_a, exp_q);
      check_q("top_rd_b", rd_q_b, exp_rd_q);
      check("top_fin_a", 32'(n_fin_a), 32'd1);

      // asynchronous reset mid-RUN, off the clock edge
      clear_rec();
      do_play(16'h0000, 16'h0003);
      wait_words_a("ar_wait", 1);
      @(negedge clock);
      #2 reset = 1'b1;
      #1;
      check("ar_ser_en",   32'(ser_enable_a), 32'd0);
      check("ar_ser_data", 32'(ser_data_a),   32'd0);
      check("ar_busy",     32'(busy_a),       32'd0);
      check("ar_mem_rd",   32'(mem_rd_a),     32'd0);
      check("ar_mem_addr", 32'(mem_addr_a),   32'd0);
      check("ar_finished", 32'(finished_a),   32'd0);
      check("ar_busy_b",   32'(busy_b),       32'd0);
      @(negedge clock);
      reset = 1'b0;

      // play and stop together: stop wins
      clear_rec();
      @(negedge clock);
      start_addr = 16'h0000; end_addr = 16'h0003; play = 1'b1; stop = 1'b1;
      @(negedge clock);
      play = 1'b0; stop = 1'b0;
      check("ps_busy",   32'(busy_a),      32'd0);
      check("ps_mem_rd", 32'(mem_rd_a),    32'd0);
      check("ps_state",  32'(dbg_state_a), 32'd0);
      repeat (5) @(negedge clock);
      check("ps_rd_cnt",  32'(rd_q_a.size()), 32'd0);
      check("ps_fin_cnt", 32'(n_fin_a),       32'd0);

`ifdef AUDIO_LOOP_EN
      // looping over two words, then loop dropped
      clear_rec();
      loop = 1'b1;
      do_play(16'h0000, 16'h0001);
      wait_words_a("loop_wait", 5);
      loop = 1'b0;
      wait_idle("loop_idle");
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(mem[0]);
         exp_q.push_back(mem[1]);
      end
      check_q("loop_words_a", word_q_a, exp_q);
      for (int i = 0; i < 6 && i < rd_q_a.size(); i++)
         check($sformatf("loop_rd[%0d]", i), 32'(rd_q_a[i]), 32'(i % 2));
      check("loop_rise_a", 32'(n_rise_a), 32'd1);
      check("loop_en_a",   32'(n_en_a),   32'd96);
      check("loop_fin_a",  32'(n_fin_a),  32'd1);
`endif

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
